adc_sample_emulator: RTL
========================

ADC_SAMPLE_EMULATOR -- requirements
Module: adc_sample_emulator

Interface
REQ-001 Parameter DATA_W, default 16, width of DATA_OUT and FIXED_WORD.
REQ-002 Parameter DIV_W, default 8, width of CNV_DIV.
REQ-003 CLK  input  1  single system clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  level; high = generate frames, low = stop after current frame.
REQ-006 CNV_DIV  input  DIV_W  CNVCLK half-period in CLK cycles.
REQ-007 FRAME_LEN  input  16  conversions per frame.
REQ-008 PATTERN_SEL  input  2  0 counter, 1 fixed word, 2 LFSR, 3 walking one.
REQ-009 FIXED_WORD  input  DATA_W  pattern for PATTERN_SEL=1.
REQ-010 CNVCLK  output  1  generated conversion clock, registered.
REQ-011 DATA_OUT  output  DATA_W  emulated ADC word, registered.
REQ-012 SR_OUT  output  1  frame marker, high for first conversion of each frame.
REQ-013 BUSY  output  1  high in RUN or DRAIN.
REQ-014 FRAME_DONE  output  1  one-CLK pulse at end of each frame.

Function
REQ-015 States IDLE, RUN, DRAIN; IDLE->RUN when START=1; RUN->DRAIN when frame completes with START=0; DRAIN->IDLE after final CNVCLK low half-period.
REQ-016 CNV_DIV, FRAME_LEN, PATTERN_SEL, FIXED_WORD latched on IDLE->RUN and at each frame boundary; changes mid-frame have no effect.
REQ-017 CNV_DIV values 0 and 1 are treated as 2; FRAME_LEN=0 is treated as 1.
REQ-018 In RUN, CNVCLK toggles every CNV_DIV CLK cycles; first rising edge occurs CNV_DIV cycles after RUN entry; CNVCLK is low in IDLE.
REQ-019 DATA_OUT and SR_OUT update only on the CLK edge that drives CNVCLK high, so both are stable across the following CNVCLK falling edge.
REQ-020 Counter pattern: 0 at first conversion after RUN entry, +1 per conversion, wraps 16'hFFFF->0, continues across frames.
REQ-021 Walking-one pattern: 16'h0001 at first conversion after RUN entry, rotate left per conversion, 16'h8000->16'h0001.
REQ-022 SR_OUT = 1 for exactly the first conversion of each frame, 0 for all others.
REQ-023 Conversion counter compares against latched FRAME_LEN; FRAME_DONE pulses on the CLK edge where CNVCLK falls after conversion FRAME_LEN.
REQ-024 START high at frame end: next frame starts with no gap in CNVCLK; START low: DRAIN, no further rising CNVCLK edges.
REQ-025 START deasserted mid-frame: current frame completes in full.
REQ-026 BUSY falls on the same edge as the DRAIN->IDLE transition; DATA_OUT holds last value in IDLE.

Reset
REQ-027 RST low asynchronously forces IDLE, CNVCLK=0, DATA_OUT=0, SR_OUT=0, BUSY=0, FRAME_DONE=0, all counters 0, LFSR to seed.
REQ-028 Reset mid-frame aborts with no FRAME_DONE; after release, operation restarts from REQ-015.

Configuration
REQ-029 Macro ADC_SAMPLE_EMULATOR_LFSR_EN defined: PATTERN_SEL=2 outputs 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1 at RUN entry, one step per conversion.
REQ-030 Macro undefined: no LFSR logic; PATTERN_SEL=2 behaves identically to PATTERN_SEL=0.

Verification
REQ-031 CNV_DIV=4, FRAME_LEN=3, PATTERN_SEL=0, START held high -> CNVCLK period 8 CLK; DATA_OUT 0,1,2,3,...; SR_OUT high with words 0 and 3; FRAME_DONE every 24 CLK.
REQ-032 CNV_DIV=1, FRAME_LEN=0, PATTERN_SEL=1, FIXED_WORD=16'hBEEF -> CNVCLK period 4 CLK, DATA_OUT=16'hBEEF, SR_OUT high every conversion.
REQ-033 PATTERN_SEL=3, FRAME_LEN=20 -> DATA_OUT 0001,0002,...,8000,0001; START dropped at conversion 5 -> 20 conversions, FRAME_DONE, BUSY low, CNVCLK low.
REQ-034 LFSR_EN defined, PATTERN_SEL=2 -> first words ACE1, 5670, AB38; undefined -> 0,1,2.
REQ-035 RST low at conversion 2 of 5 -> all outputs 0 immediately, no FRAME_DONE; after release with START=1, DATA_OUT restarts at 0 with SR_OUT=1.
REQ-036 CNV_DIV changed 4->6 mid-frame -> period stays 8 CLK until frame boundary, then 12 CLK.

Source files
------------

// File: rtl/adc_sample_emulator.sv
// Emulated ADC: divided conversion clock, framed data words with a frame marker.
// Define ADC_SAMPLE_EMULATOR_LFSR_EN to add the LFSR pattern on PATTERN_SEL=2.
module adc_sample_emulator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DIV_W-1:0]  CNV_DIV,
  input  logic [15:0]       FRAME_LEN,
  input  logic [1:0]        PATTERN_SEL,
  input  logic [DATA_W-1:0] FIXED_WORD,
  output logic              CNVCLK,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              SR_OUT,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         sel_q, sel_d;
  logic [DATA_W-1:0]  fixed_q, fixed_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [15:0]        conv_cnt_q, conv_cnt_d;
  logic               cnvclk_q, cnvclk_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sr_q, sr_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  cnt_pat_q, cnt_pat_d;
  logic [DATA_W-1:0]  walk_q, walk_d;
  logic [DIV_W-1:0]   div_in;
  logic [15:0]        len_in;
  logic [DATA_W-1:0]  pattern;
  logic               half_done;
  logic               cfg_load;

`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_next;
  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif

  // Degenerate settings are clamped before they are latched.
  assign div_in    = (CNV_DIV < DIV_W'(2)) ? DIV_W'(2) : CNV_DIV;
  assign len_in    = (FRAME_LEN == 16'd0) ? 16'd1 : FRAME_LEN;
  assign half_done = (div_cnt_q == div_q - DIV_W'(1));

  always_comb begin
    pattern = cnt_pat_q;
    case (sel_q)
      2'd1:    pattern = fixed_q;
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
      2'd2:    pattern = DATA_W'(lfsr_q);
`endif
      2'd3:    pattern = walk_q;
      default: pattern = cnt_pat_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    len_d      = len_q;
    sel_d      = sel_q;
    fixed_d    = fixed_q;
    div_cnt_d  = div_cnt_q;
    conv_cnt_d = conv_cnt_q;
    cnvclk_d   = cnvclk_q;
    data_d     = data_q;
    sr_d       = sr_q;
    done_d     = 1'b0;
    cnt_pat_d  = cnt_pat_q;
    walk_d     = walk_q;
    cfg_load   = 1'b0;
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
    lfsr_d     = lfsr_q;
`endif
    case (state_q)
      StIdle: begin
        if (START) begin
          state_d    = StRun;
          cfg_load   = 1'b1;
          div_cnt_d  = '0;
          conv_cnt_d = '0;
          cnt_pat_d  = '0;
          walk_d     = DATA_W'(1);
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
          lfsr_d     = LfsrSeed;
`endif
        end
      end
      StRun: begin
        if (half_done) begin
          div_cnt_d = '0;
          cnvclk_d  = ~cnvclk_q;
          if (!cnvclk_q) begin
            // Rising edge: the word and marker change only here.
            data_d     = pattern;
            sr_d       = (conv_cnt_q == 16'd0);
            conv_cnt_d = conv_cnt_q + 16'd1;
            cnt_pat_d  = cnt_pat_q + DATA_W'(1);
            walk_d     = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
            lfsr_d     = lfsr_next;
`endif
          end else if (conv_cnt_q == len_q) begin
            done_d     = 1'b1;
            conv_cnt_d = '0;
            cfg_load   = 1'b1;
            if (!START) state_d = StDrain;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      StDrain: begin
        if (half_done) begin
          state_d   = StIdle;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (cfg_load) begin
      div_d   = div_in;
      len_d   = len_in;
      sel_d   = PATTERN_SEL;
      fixed_d = FIXED_WORD;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      div_q      <= '0;
      len_q      <= '0;
      sel_q      <= '0;
      fixed_q    <= '0;
      div_cnt_q  <= '0;
      conv_cnt_q <= '0;
      cnvclk_q   <= 1'b0;
      data_q     <= '0;
      sr_q       <= 1'b0;
      done_q     <= 1'b0;
      cnt_pat_q  <= '0;
      walk_q     <= DATA_W'(1);
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
      lfsr_q     <= LfsrSeed;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      len_q      <= len_d;
      sel_q      <= sel_d;
      fixed_q    <= fixed_d;
      div_cnt_q  <= div_cnt_d;
      conv_cnt_q <= conv_cnt_d;
      cnvclk_q   <= cnvclk_d;
      data_q     <= data_d;
      sr_q       <= sr_d;
      done_q     <= done_d;
      cnt_pat_q  <= cnt_pat_d;
      walk_q     <= walk_d;
`ifdef ADC_SAMPLE_EMULATOR_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign CNVCLK     = cnvclk_q;
  assign DATA_OUT   = data_q;
  assign SR_OUT     = sr_q;
  assign BUSY       = (state_q != StIdle);
  assign FRAME_DONE = done_q;

endmodule
